a2bus_drive_arbiter: RTL and testbench

A2BUS_DRIVE_ARBITER -- requirements
Module: a2bus_drive_arbiter

---
 rtl/a2bus_drive_arbiter_pkg.sv | 36 +++
 rtl/a2bus_drive_arbiter_rr_picker.sv | 42 ++++
 rtl/a2bus_drive_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_a2bus_drive_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2bus_drive_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// a2bus_drive_arbiter_pkg
// Types and constants shared by the Apple II bus read-drive arbiter and its
// round-robin picker.
//   a2_state_e     : arbiter FSM state encoding (also exported for debug)
//   A2_DRIVE_DELAY : default logic-clock cycles from phi0 rise to driver enable
//   A2_HOLD_COUNT  : default logic-clock cycles the driver stays on after phi0 fall
//   A2_CNT_W       : width of the delay/hold down-counter
//   A2_WD_W/LIMIT  : width and terminal value of the ARMED no-clock watchdog
//   multi_hot()    : true when more than one bit of a request vector is set
// ---------------------------------------------------------------------------
package a2bus_drive_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_DRIVE = 3'd3,
    ST_HOLD  = 3'd4
  } a2_state_e;

  localparam int A2_DRIVE_DELAY = 4;
  localparam int A2_HOLD_COUNT  = 2;
  localparam int A2_CNT_W       = 8;
  localparam int A2_WD_W        = 6;

  // ARMED is abandoned on the 63rd cycle without a phi0 rising edge: the
  // watchdog counts 0..62 while waiting and fires when it already holds 62.
  localparam logic [A2_WD_W-1:0] A2_WD_LIMIT = 6'd62;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/a2bus_drive_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin priority picker.
//   req_i   [NUM_REQ] : request vector
//   ptr_i   [PTR_W]   : index of the last granted requester
//   grant_o [NUM_REQ] : one-hot grant, zero when req_i is zero
// The search starts at ptr_i+1 and wraps from NUM_REQ-1 to 0, so the last
// winner is examined last.
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic             w_found;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    grant_o = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // ptr_i < NUM_REQ and k <= NUM_REQ, so one conditional subtract wraps.
      w_sum = {1'b0, ptr_i} + (PTR_W + 1)'(k);
      if (w_sum >= (PTR_W + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W + 1)'(NUM_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && req_i[w_idx]) begin
        grant_o[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/a2bus_drive_arbiter.sv
// ---------------------------------------------------------------------------
// a2bus_drive_arbiter
// Decides which internal card answers an Apple II bus read cycle and times
// the external data driver enable against phi0.
//   clk_logic_i      : logic clock, the only clock
//   reset_i          : synchronous active-high reset
//   phi0_posedge_i   : one-cycle pulse at phi0 rise
//   phi0_negedge_i   : one-cycle pulse at phi0 fall
//   addr_strobe_i    : one-cycle pulse when address and rw_n_i are sampled
//   rw_n_i           : bus R/W (1 = read), valid with addr_strobe_i
//   req_i  [NUM_REQ] : per-card claim of the current read cycle
//   data_i [NUM_REQ][8] : per-card read data, captured at phi0 rise
//   grant_o [NUM_REQ]: one-hot owner of the current cycle, zero when none
//   data_o [8]       : captured data of the granted card
//   data_oe_o        : registered enable for the external bus driver
//   conflict_o       : pulse when several cards claimed the same read
//   error_o          : pulse when addr_strobe_i arrives outside IDLE
//   state_o          : current FSM state, for debug and checkers
// All pulse inputs are single-cycle strobes in the clk_logic_i domain; there
// is no back-pressure, an event is consumed in the cycle it is presented.
// ---------------------------------------------------------------------------
module a2bus_drive_arbiter
  import a2bus_drive_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DRIVE_DELAY = A2_DRIVE_DELAY,
  parameter int HOLD_COUNT  = A2_HOLD_COUNT
) (
  input  logic                    clk_logic_i,
  input  logic                    reset_i,
  input  logic                    phi0_posedge_i,
  input  logic                    phi0_negedge_i,
  input  logic                    addr_strobe_i,
  input  logic                    rw_n_i,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0][7:0] data_i,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic [7:0]              data_o,
  output logic                    data_oe_o,
  output logic                    conflict_o,
  output logic                    error_o,
  output a2_state_e               state_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [A2_CNT_W-1:0] C_DRIVE = A2_CNT_W'(DRIVE_DELAY);
  localparam logic [A2_CNT_W-1:0] C_HOLD  = A2_CNT_W'(HOLD_COUNT);
  localparam logic [A2_CNT_W-1:0] C_ONE   = A2_CNT_W'(1);

  a2_state_e           r_state, w_state_nx;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nx;
  logic [PTR_W-1:0]    r_ptr, w_ptr_nx;
  logic [7:0]          r_data, w_data_nx;
  logic                r_oe, w_oe_nx;
  logic                r_conflict, w_conflict_nx;
  logic                r_error, w_error_nx;
  logic [A2_CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [A2_WD_W-1:0]  r_wd, w_wd_nx;

  logic [NUM_REQ-1:0]  w_pick;
  logic [PTR_W-1:0]    w_pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req_i   (req_i),
    .ptr_i   (r_ptr),
    .grant_o (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick[k]) w_pick_idx = PTR_W'(k);
    end
  end

  // Next-state and next-output logic. The pointer register doubles as the
  // index of the granted card, which is what selects data_i at capture.
  always_comb begin
    w_state_nx    = r_state;
    w_grant_nx    = r_grant;
    w_ptr_nx      = r_ptr;
    w_data_nx     = r_data;
    w_oe_nx       = r_oe;
    w_cnt_nx      = r_cnt;
    w_wd_nx       = r_wd;
    w_conflict_nx = 1'b0;
    w_error_nx    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (addr_strobe_i && rw_n_i && (req_i != '0)) begin
          w_state_nx    = ST_ARMED;
          w_grant_nx    = w_pick;
          w_ptr_nx      = w_pick_idx;
          w_wd_nx       = '0;
          w_conflict_nx = multi_hot(8'(req_i));
        end
      end

      ST_ARMED: begin
        if (phi0_posedge_i) begin
          w_data_nx  = data_i[r_ptr];
          w_cnt_nx   = C_DRIVE;
          w_state_nx = ST_DELAY;
        end else if (r_wd == A2_WD_LIMIT) begin
          // phi0 has stopped (sleep / no bus clock): give the cycle up.
          w_state_nx = ST_IDLE;
          w_grant_nx = '0;
        end else begin
          w_wd_nx = r_wd + 1'b1;
        end
      end

      ST_DELAY: begin
        // A phi0 fall before the delay expires means the window is gone;
        // the driver is never turned on for this cycle.
        if (phi0_negedge_i) begin
          w_cnt_nx   = C_HOLD;
          w_state_nx = ST_HOLD;
        end else if (r_cnt <= C_ONE) begin
          w_cnt_nx   = '0;
          w_oe_nx    = 1'b1;
          w_state_nx = ST_DRIVE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end

      ST_DRIVE: begin
        if (phi0_negedge_i) begin
          w_cnt_nx   = C_HOLD;
          w_state_nx = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (r_cnt <= C_ONE) begin
          w_cnt_nx   = '0;
          w_oe_nx    = 1'b0;
          w_grant_nx = '0;
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
        w_oe_nx    = 1'b0;
        w_grant_nx = '0;
        w_cnt_nx   = '0;
      end
    endcase

    // A strobe outside IDLE is only reported; it never disturbs the cycle.
    if (addr_strobe_i && (r_state != ST_IDLE)) begin
      w_error_nx = 1'b1;
    end
  end

  always_ff @(posedge clk_logic_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_data     <= 8'h00;
      r_oe       <= 1'b0;
      r_conflict <= 1'b0;
      r_error    <= 1'b0;
      r_cnt      <= '0;
      r_wd       <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_ptr      <= w_ptr_nx;
      r_data     <= w_data_nx;
      r_oe       <= w_oe_nx;
      r_conflict <= w_conflict_nx;
      r_error    <= w_error_nx;
      r_cnt      <= w_cnt_nx;
      r_wd       <= w_wd_nx;
    end
  end

  assign grant_o    = r_grant;
  assign data_o     = r_data;
  assign data_oe_o  = r_oe;
  assign conflict_o = r_conflict;
  assign error_o    = r_error;
  assign state_o    = r_state;

endmodule

// File: tb/tb_a2bus_drive_arbiter.sv
module tb_a2bus_drive_arbiter;
  import a2bus_drive_arbiter_pkg::*;

  localparam int EXP_DELAY = 4;
  localparam int EXP_HOLD  = 2;
  localparam int EXP_SLEEP = 63;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             phi0_posedge_i = 1'b0;
  logic             phi0_negedge_i = 1'b0;
  logic             addr_strobe_i = 1'b0;
  logic             rw_n_i = 1'b1;
  logic [3:0]       req_i = '0;
  logic [3:0][7:0]  data_i = '0;
  logic [3:0]       grant_o;
  logic [7:0]       data_o;
  logic             data_oe_o;
  logic             conflict_o;
  logic             error_o;
  a2_state_e        state_o;

  always #5 clk = ~clk;

  a2bus_drive_arbiter #(
    .NUM_REQ     (4),
    .DRIVE_DELAY (4),
    .HOLD_COUNT  (2)
  ) dut (
    .clk_logic_i    (clk),
    .reset_i        (reset_i),
    .phi0_posedge_i (phi0_posedge_i),
    .phi0_negedge_i (phi0_negedge_i),
    .addr_strobe_i  (addr_strobe_i),
    .rw_n_i         (rw_n_i),
    .req_i          (req_i),
    .data_i         (data_i),
    .grant_o        (grant_o),
    .data_o         (data_o),
    .data_oe_o      (data_oe_o),
    .conflict_o     (conflict_o),
    .error_o        (error_o),
    .state_o        (state_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits until data_oe_o reaches level; n = clock edges taken (100 = timeout).
  task automatic wait_oe(input logic level, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (data_oe_o !== level && n < 100);
  endtask

  task automatic strobe(input logic rw, input logic [3:0] req, input logic [3:0][7:0] dat);
    rw_n_i = rw; req_i = req; data_i = dat; addr_strobe_i = 1'b1;
    tick();
    addr_strobe_i = 1'b0; rw_n_i = 1'b1;
  endtask

  task automatic pulse_pos();
    phi0_posedge_i = 1'b1; tick(); phi0_posedge_i = 1'b0;
  endtask

  task automatic pulse_neg();
    phi0_negedge_i = 1'b1; tick(); phi0_negedge_i = 1'b0;
  endtask

  task automatic run_read(input string nm, input logic [3:0] req, input logic [3:0][7:0] dat,
                          input logic [3:0] eg, input logic ec, input logic [7:0] ed);
    int n;
    logic [7:0] exp_d;
    exp_q.push_back(ed);
    strobe(1'b1, req, dat);
    chk({nm, "_grant"}, 32'(grant_o), 32'(eg));
    chk({nm, "_conflict"}, 32'(conflict_o), 32'(ec));
    chk({nm, "_armed"}, 32'(state_o), 32'(ST_ARMED));
    tick();
    chk({nm, "_conflict_clr"}, 32'(conflict_o), 32'(0));
    req_i = '0;              // claim dropped mid-cycle: must not matter
    pulse_pos();
    data_i = ~dat;           // data changes after capture: must not matter
    chk({nm, "_oe_delay0"}, 32'(data_oe_o), 32'(0));
    wait_oe(1'b1, n);
    chk({nm, "_oe_rise"}, 32'(n), 32'(EXP_DELAY));
    exp_d = exp_q.pop_front();
    chk({nm, "_data"}, 32'(data_o), 32'(exp_d));
    chk({nm, "_grant_frozen"}, 32'(grant_o), 32'(eg));
    tick();
    pulse_neg();
    chk({nm, "_oe_hold"}, 32'(data_oe_o), 32'(1));
    wait_oe(1'b0, n);
    chk({nm, "_oe_fall"}, 32'(n), 32'(EXP_HOLD));
    chk({nm, "_grant_clr"}, 32'(grant_o), 32'(0));
    chk({nm, "_idle"}, 32'(state_o), 32'(ST_IDLE));
  endtask

  task automatic run_write(input string nm, input logic [3:0] req);
    logic seen;
    strobe(1'b0, req, '0);
    chk({nm, "_grant"}, 32'(grant_o), 32'(0));
    chk({nm, "_conflict"}, 32'(conflict_o), 32'(0));
    chk({nm, "_idle"}, 32'(state_o), 32'(ST_IDLE));
    seen = 1'b0;
    pulse_pos();
    for (int i = 0; i < 6; i++) begin
      seen = seen | data_oe_o;
      tick();
    end
    pulse_neg();
    seen = seen | data_oe_o;
    chk({nm, "_no_oe"}, 32'(seen), 32'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            rw_n;
    logic [3:0]      req;
    logic [3:0][7:0] data;
    logic [3:0]      exp_grant;
    logic            exp_conflict;
    logic [7:0]      exp_data;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic rw, input logic [3:0] req, input logic [31:0] dat,
                              input logic [3:0] eg, input logic ec, input logic [7:0] ed);
    vec_t v;
    v.rw_n = rw; v.req = req; v.data = dat;
    v.exp_grant = eg; v.exp_conflict = ec; v.exp_data = ed;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic seen;

    // Pointer walk from reset: 0 ->1 ->2 ->3 ->(write) ->2 ->0 ->3 ->1 ->(write) ->0 ->1
    vecs[0]  = mk(1'b1, 4'b1111, 32'h13121110, 4'b0010, 1'b1, 8'h11);
    vecs[1]  = mk(1'b1, 4'b1111, 32'h23222120, 4'b0100, 1'b1, 8'h22);
    vecs[2]  = mk(1'b1, 4'b1111, 32'h33323130, 4'b1000, 1'b1, 8'h33);
    vecs[3]  = mk(1'b0, 4'b0001, 32'h0,        4'b0000, 1'b0, 8'h00);
    vecs[4]  = mk(1'b1, 4'b0100, 32'h11A52233, 4'b0100, 1'b0, 8'hA5);
    vecs[5]  = mk(1'b1, 4'b0011, 32'h53525150, 4'b0001, 1'b1, 8'h50);
    vecs[6]  = mk(1'b1, 4'b1001, 32'h63626160, 4'b1000, 1'b1, 8'h63);
    vecs[7]  = mk(1'b1, 4'b0010, 32'h73727170, 4'b0010, 1'b0, 8'h71);
    vecs[8]  = mk(1'b0, 4'b1111, 32'h0,        4'b0000, 1'b0, 8'h00);
    vecs[9]  = mk(1'b1, 4'b0001, 32'h93929190, 4'b0001, 1'b0, 8'h90);
    vecs[10] = mk(1'b1, 4'b1110, 32'hA3A2A1A0, 4'b0010, 1'b1, 8'hA1);

    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    chk("rst_grant", 32'(grant_o), 32'(0));
    chk("rst_data", 32'(data_o), 32'(0));
    chk("rst_oe", 32'(data_oe_o), 32'(0));
    chk("rst_conflict", 32'(conflict_o), 32'(0));
    chk("rst_error", 32'(error_o), 32'(0));
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rw_n)
        run_read($sformatf("v%0d", i), vecs[i].req, vecs[i].data,
                 vecs[i].exp_grant, vecs[i].exp_conflict, vecs[i].exp_data);
      else
        run_write($sformatf("v%0d", i), vecs[i].req);
    end

    // Extra strobe while ARMED (pointer 1 -> grant index 2)
    strobe(1'b1, 4'b0100, 32'hB3B2B1B0);
    chk("armstb_grant", 32'(grant_o), 32'(4'b0100));
    strobe(1'b1, 4'b1000, 32'hB3B2B1B0);
    chk("armstb_error", 32'(error_o), 32'(1));
    chk("armstb_grant_keep", 32'(grant_o), 32'(4'b0100));
    chk("armstb_state", 32'(state_o), 32'(ST_ARMED));
    tick();
    chk("armstb_error_clr", 32'(error_o), 32'(0));
    pulse_pos();
    wait_oe(1'b1, n);
    chk("armstb_oe_rise", 32'(n), 32'(EXP_DELAY));
    chk("armstb_data", 32'(data_o), 32'(8'hB2));
    pulse_neg();
    wait_oe(1'b0, n);
    chk("armstb_oe_fall", 32'(n), 32'(EXP_HOLD));

    // Extra strobe during DRIVE (pointer 2 -> grant index 3)
    strobe(1'b1, 4'b1000, 32'hC3C2C1C0);
    chk("drvstb_grant", 32'(grant_o), 32'(4'b1000));
    pulse_pos();
    wait_oe(1'b1, n);
    chk("drvstb_oe_rise", 32'(n), 32'(EXP_DELAY));
    strobe(1'b1, 4'b0001, 32'hDEADBEEF);
    chk("drvstb_error", 32'(error_o), 32'(1));
    chk("drvstb_grant_keep", 32'(grant_o), 32'(4'b1000));
    chk("drvstb_data_keep", 32'(data_o), 32'(8'hC3));
    chk("drvstb_state", 32'(state_o), 32'(ST_DRIVE));
    tick();
    chk("drvstb_error_clr", 32'(error_o), 32'(0));
    pulse_neg();
    wait_oe(1'b0, n);
    chk("drvstb_oe_fall", 32'(n), 32'(EXP_HOLD));

    // phi0 falls before the drive delay expires (pointer 3 -> grant index 0)
    strobe(1'b1, 4'b0001, 32'hD3D2D1D0);
    chk("early_grant", 32'(grant_o), 32'(4'b0001));
    pulse_pos();
    tick();
    pulse_neg();
    chk("early_state", 32'(state_o), 32'(ST_HOLD));
    chk("early_oe", 32'(data_oe_o), 32'(0));
    seen = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      seen = seen | data_oe_o;
    end while (state_o != ST_IDLE && n < 100);
    chk("early_hold_len", 32'(n), 32'(EXP_HOLD));
    chk("early_no_oe", 32'(seen), 32'(0));
    chk("early_grant_clr", 32'(grant_o), 32'(0));

    // No phi0 edges after the strobe (pointer 0 -> grant index 1)
    strobe(1'b1, 4'b0010, 32'hE3E2E1E0);
    chk("sleep_grant", 32'(grant_o), 32'(4'b0010));
    seen = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      seen = seen | data_oe_o;
    end while (state_o != ST_IDLE && n < 100);
    chk("sleep_len", 32'(n), 32'(EXP_SLEEP));
    chk("sleep_no_oe", 32'(seen), 32'(0));
    chk("sleep_grant_clr", 32'(grant_o), 32'(0));

    // Reset two cycles into DRIVE (pointer 1 -> grant index 2)
    strobe(1'b1, 4'b0100, 32'hF3F2F1F0);
    chk("rstdrv_grant", 32'(grant_o), 32'(4'b0100));
    pulse_pos();
    wait_oe(1'b1, n);
    chk("rstdrv_oe_rise", 32'(n), 32'(EXP_DELAY));
    tick();
    tick();
    chk("rstdrv_in_drive", 32'(state_o), 32'(ST_DRIVE));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("rstdrv_oe", 32'(data_oe_o), 32'(0));
    chk("rstdrv_grant_clr", 32'(grant_o), 32'(0));
    chk("rstdrv_state", 32'(state_o), 32'(ST_IDLE));
    chk("rstdrv_data", 32'(data_o), 32'(0));
    run_read("post_rst", 4'b0001, 32'h07060504, 4'b0001, 1'b0, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
